us_cmd_tlp_tx: RTL and testbench



---
 rtl/us_tlp_pkg.sv | 53 +++++
 rtl/us_cmd_tlp_tx.sv | 214 +++++++++++++++++++++
 tb/tb_us_cmd_tlp_tx.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/us_tlp_pkg.sv
// Shared definitions for the upstream command -> PCIe request TLP path.
//   - fmt constants for the four supported request formats
//   - bit offsets/widths of the fields in the 128-bit upstream command word
//   - FSM state type used by us_cmd_tlp_tx
//   - helper functions that build the header DWs
package us_tlp_pkg;

    localparam logic [1:0] FMT_MRD32 = 2'b00;
    localparam logic [1:0] FMT_MRD64 = 2'b01;
    localparam logic [1:0] FMT_MWR32 = 2'b10;
    localparam logic [1:0] FMT_MWR64 = 2'b11;

    localparam int CMD_ADDR_LO_LSB = 0;
    localparam int CMD_ADDR_HI_LSB = 32;
    localparam int CMD_ADDR_W      = 32;
    localparam int CMD_DATA_LSB    = 64;
    localparam int CMD_DATA_W      = 32;
    localparam int CMD_LEN_LSB     = 96;
    localparam int CMD_LEN_W       = 10;
    localparam int CMD_RSVD_LSB    = 106;
    localparam int CMD_RSVD_W      = 13;
    localparam int CMD_TAG_LSB     = 119;
    localparam int CMD_TAG_W       = 8;
    localparam int CMD_OP_BIT      = 127;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_LOAD = 3'd2,
        ST_HDR0 = 3'd3,
        ST_HDR1 = 3'd4,
        ST_HDR2 = 3'd5,
        ST_HDR3 = 3'd6,
        ST_DATA = 3'd7
    } tlp_state_t;

    // DW0: fmt, type=MEM, TC/TD/EP/attr all zero, length (0 means 1024 DW).
    function automatic logic [31:0] build_dw0(input logic [1:0] fmt, input logic [9:0] len);
        return {1'b0, fmt, 5'b00000, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, len};
    endfunction

    // DW1: requester ID, tag, last BE (must be 0 for single-DW requests), first BE.
    function automatic logic [31:0] build_dw1(input logic [15:0] req_id, input logic [7:0] tag,
                                              input logic [9:0] len);
        return {req_id, tag, ((len == 10'd1) ? 4'h0 : 4'hF), 4'hF};
    endfunction

    // DW-aligned lower address; the two byte-offset bits are not carried.
    function automatic logic [31:0] build_addr_lo(input logic [31:0] addr_lo);
        return {addr_lo[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/us_cmd_tlp_tx.sv
// us_cmd_tlp_tx: pops one 128-bit upstream command from us_cmd_fifo and sends it
// as a single MRd or MWr request TLP on the 32-bit TRN TX interface.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   fifo_dout/fifo_empty        command word and empty flag from us_cmd_fifo
//   fifo_rd_en                  one-cycle pop strobe
//   cfg_completer_id            requester ID placed in DW1
//   cfg_bus_mstr_enable         new commands are only popped while set
//   trn_td/trn_tsof_n/trn_teof_n/trn_tsrc_rdy_n/trn_tsrc_dsc_n   TRN TX source side
//   trn_tdst_rdy_n, trn_tbuf_av TRN TX sink side
//   busy                        command being fetched or transmitted
//   tlp_cnt                     wrapping count of completed TLPs
//
// Build option: define US_CMD_TLP_ADDR64_EN to send a 4DW header whenever
// addr_hi is non-zero; otherwise addr_hi is ignored and all headers are 3DW.
module us_cmd_tlp_tx
    import us_tlp_pkg::*;
#(
    parameter logic [5:0] BUF_AV_MIN = 6'd1,
    parameter logic [7:0] MWR_TAG    = 8'h00
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] fifo_dout,
    input  logic         fifo_empty,
    output logic         fifo_rd_en,
    input  logic [15:0]  cfg_completer_id,
    input  logic         cfg_bus_mstr_enable,
    output logic [31:0]  trn_td,
    output logic         trn_tsof_n,
    output logic         trn_teof_n,
    output logic         trn_tsrc_rdy_n,
    output logic         trn_tsrc_dsc_n,
    input  logic         trn_tdst_rdy_n,
    input  logic [5:0]   trn_tbuf_av,
    output logic         busy,
    output logic [15:0]  tlp_cnt
);

    tlp_state_t   state_r, state_next_s;
    logic [127:0] cmd_r, cmd_s;
    logic [31:0]  td_r, td_next_s;
    logic         sof_n_r, sof_n_next_s;
    logic         eof_n_r, eof_n_next_s;
    logic         src_rdy_n_r, src_rdy_n_next_s;
    logic         rd_en_r, busy_r;
    logic [15:0]  tlp_cnt_r;
    logic         accept_s, is_wr_s, is_64_s;
    logic [1:0]   fmt_s;
    logic [9:0]   len_s;
    logic [7:0]   tag_s;
    logic [31:0]  addr_lo_s, addr_hi_s, data_s;
    logic         unused_bits_s;

    // A beat moves only when both sides of the TRN handshake are ready.
    assign accept_s = !src_rdy_n_r && !trn_tdst_rdy_n;

    // Decode the command; in LOAD the word is still on fifo_dout, so the
    // first header beat is built straight from it.
    always_comb begin
        cmd_s     = (state_r == ST_LOAD) ? fifo_dout : cmd_r;
        is_wr_s   = cmd_s[CMD_OP_BIT];
        addr_lo_s = cmd_s[CMD_ADDR_LO_LSB +: CMD_ADDR_W];
        addr_hi_s = cmd_s[CMD_ADDR_HI_LSB +: CMD_ADDR_W];
        data_s    = cmd_s[CMD_DATA_LSB +: CMD_DATA_W];
`ifdef US_CMD_TLP_ADDR64_EN
        is_64_s   = (addr_hi_s != 32'h0000_0000);
`else
        is_64_s   = 1'b0;
`endif
        len_s     = is_wr_s ? 10'd1 : cmd_s[CMD_LEN_LSB +: CMD_LEN_W];
        tag_s     = is_wr_s ? MWR_TAG : cmd_s[CMD_TAG_LSB +: CMD_TAG_W];
        if (is_wr_s) begin
            fmt_s = is_64_s ? FMT_MWR64 : FMT_MWR32;
        end else begin
            fmt_s = is_64_s ? FMT_MRD64 : FMT_MRD32;
        end
    end

    // Fields that never reach the wire.
    assign unused_bits_s = ^{cmd_s[CMD_RSVD_LSB +: CMD_RSVD_W], addr_hi_s};

    // Next state, plus the registered TRN values for the beat of that state.
    always_comb begin
        state_next_s     = state_r;
        td_next_s        = td_r;
        sof_n_next_s     = sof_n_r;
        eof_n_next_s     = eof_n_r;
        src_rdy_n_next_s = src_rdy_n_r;

        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty && cfg_bus_mstr_enable && (trn_tbuf_av >= BUF_AV_MIN)) begin
                    state_next_s = ST_POP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_POP:  state_next_s = ST_LOAD;
            ST_LOAD: state_next_s = ST_HDR0;
            ST_HDR0: state_next_s = accept_s ? ST_HDR1 : ST_HDR0;
            ST_HDR1: state_next_s = accept_s ? ST_HDR2 : ST_HDR1;
            ST_HDR2: begin
                if (!accept_s) begin
                    state_next_s = ST_HDR2;
                end else if (is_64_s) begin
                    state_next_s = ST_HDR3;
                end else begin
                    state_next_s = is_wr_s ? ST_DATA : ST_IDLE;
                end
            end
`ifdef US_CMD_TLP_ADDR64_EN
            ST_HDR3: begin
                if (accept_s) begin
                    state_next_s = is_wr_s ? ST_DATA : ST_IDLE;
                end else begin
                    state_next_s = ST_HDR3;
                end
            end
`endif
            ST_DATA: state_next_s = accept_s ? ST_IDLE : ST_DATA;
            default: state_next_s = ST_IDLE;
        endcase

        // On a state change load the new beat; otherwise the beat holds.
        if (state_next_s != state_r) begin
            td_next_s        = 32'h0000_0000;
            sof_n_next_s     = 1'b1;
            eof_n_next_s     = 1'b1;
            src_rdy_n_next_s = 1'b1;
            case (state_next_s)
                ST_HDR0: begin
                    td_next_s        = build_dw0(fmt_s, len_s);
                    sof_n_next_s     = 1'b0;
                    src_rdy_n_next_s = 1'b0;
                end
                ST_HDR1: begin
                    td_next_s        = build_dw1(cfg_completer_id, tag_s, len_s);
                    src_rdy_n_next_s = 1'b0;
                end
                ST_HDR2: begin
                    td_next_s        = is_64_s ? addr_hi_s : build_addr_lo(addr_lo_s);
                    eof_n_next_s     = is_64_s || is_wr_s;
                    src_rdy_n_next_s = 1'b0;
                end
`ifdef US_CMD_TLP_ADDR64_EN
                ST_HDR3: begin
                    td_next_s        = build_addr_lo(addr_lo_s);
                    eof_n_next_s     = is_wr_s;
                    src_rdy_n_next_s = 1'b0;
                end
`endif
                ST_DATA: begin
                    td_next_s        = data_s;
                    eof_n_next_s     = 1'b0;
                    src_rdy_n_next_s = 1'b0;
                end
                default: begin
                    td_next_s        = 32'h0000_0000;
                    src_rdy_n_next_s = 1'b1;
                end
            endcase
        end else begin
            td_next_s        = td_r;
            sof_n_next_s     = sof_n_r;
            eof_n_next_s     = eof_n_r;
            src_rdy_n_next_s = src_rdy_n_r;
        end
    end

    // State, command capture, registered outputs and TLP counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cmd_r       <= 128'h0;
            td_r        <= 32'h0000_0000;
            sof_n_r     <= 1'b1;
            eof_n_r     <= 1'b1;
            src_rdy_n_r <= 1'b1;
            rd_en_r     <= 1'b0;
            busy_r      <= 1'b0;
            tlp_cnt_r   <= 16'h0000;
        end else begin
            state_r     <= state_next_s;
            if (state_r == ST_LOAD) begin
                cmd_r <= fifo_dout;
            end else begin
                cmd_r <= cmd_r;
            end
            td_r        <= td_next_s;
            sof_n_r     <= sof_n_next_s;
            eof_n_r     <= eof_n_next_s;
            src_rdy_n_r <= src_rdy_n_next_s;
            rd_en_r     <= (state_next_s == ST_POP);
            busy_r      <= (state_next_s != ST_IDLE);
            if (accept_s && !eof_n_r) begin
                tlp_cnt_r <= tlp_cnt_r + 16'd1;
            end else begin
                tlp_cnt_r <= tlp_cnt_r;
            end
        end
    end

    assign fifo_rd_en     = rd_en_r;
    assign trn_td         = td_r;
    assign trn_tsof_n     = sof_n_r;
    assign trn_teof_n     = eof_n_r;
    assign trn_tsrc_rdy_n = src_rdy_n_r;
    assign trn_tsrc_dsc_n = 1'b1;
    assign busy           = busy_r;
    assign tlp_cnt        = tlp_cnt_r;

endmodule

// File: tb/tb_us_cmd_tlp_tx.sv
// Directed bench for us_cmd_tlp_tx with a small FIFO model and a TRN beat recorder.
module tb_us_cmd_tlp_tx;

    localparam logic [15:0] ID = 16'h0A1B;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] fifo_dout = 128'h0;
    logic         fifo_empty = 1'b1;
    logic         fifo_rd_en;
    logic         bme = 1'b1;
    logic [31:0]  trn_td;
    logic         trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
    logic         trn_tdst_rdy_n = 1'b0;
    logic [5:0]   trn_tbuf_av = 6'd8;
    logic         busy;
    logic [15:0]  tlp_cnt;

    logic [127:0] q[$];
    logic         push_en = 1'b0;
    logic [127:0] push_data = 128'h0;

    logic [31:0]  cap_td[$];
    logic         cap_sof[$];
    logic         cap_eof[$];
    int           cap_cyc[$];
    int           cyc = 0;
    int           rd_cnt = 0;

    logic [31:0]  exp_td[$];
    logic         exp_sof[$];
    logic         exp_eof[$];

    int n_cmp = 0;
    int n_err = 0;
    int base, rd0;

    always #5 clk = ~clk;

    us_cmd_tlp_tx dut (
        .clk(clk), .rst_n(rst_n),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .cfg_completer_id(ID), .cfg_bus_mstr_enable(bme),
        .trn_td(trn_td), .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
        .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tsrc_dsc_n(trn_tsrc_dsc_n),
        .trn_tdst_rdy_n(trn_tdst_rdy_n), .trn_tbuf_av(trn_tbuf_av),
        .busy(busy), .tlp_cnt(tlp_cnt)
    );

    // Standard-read-mode FIFO: data appears the cycle after the pop.
    always @(posedge clk) begin
        if (fifo_rd_en && q.size() > 0) fifo_dout <= q.pop_front();
        if (push_en) q.push_back(push_data);
        fifo_empty <= (q.size() == 0);
    end

    // Record beats that will be accepted at the next rising edge, and pops.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && !trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
            cap_td.push_back(trn_td);
            cap_sof.push_back(trn_tsof_n);
            cap_eof.push_back(trn_teof_n);
            cap_cyc.push_back(cyc);
        end
        if (rst_n && fifo_rd_en) rd_cnt <= rd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_cmd(input logic op, input logic [7:0] tag,
                                            input logic [9:0] len, input logic [31:0] data,
                                            input logic [31:0] hi, input logic [31:0] lo);
        return {op, tag, 13'h0, len, data, hi, lo};
    endfunction

    task automatic push_cmd(input logic [127:0] c);
        push_data = c;
        push_en = 1'b1;
        @(posedge clk); #1;
        push_en = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_beats(input int target, input int budget, input string tag);
        int n = 0;
        while (cap_td.size() < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(cap_td.size() >= target), 32'd1);
    endtask

    task automatic exp_beat(input logic [31:0] td, input logic sof_n, input logic eof_n);
        exp_td.push_back(td);
        exp_sof.push_back(sof_n);
        exp_eof.push_back(eof_n);
    endtask

    task automatic check_beats(input int b, input string tag);
        for (int i = 0; i < exp_td.size(); i++) begin
            if (b + i < cap_td.size()) begin
                check($sformatf("%s_td%0d", tag, i), cap_td[b+i], exp_td[i]);
                check($sformatf("%s_flg%0d", tag, i), {30'h0, cap_sof[b+i], cap_eof[b+i]},
                      {30'h0, exp_sof[i], exp_eof[i]});
            end else begin
                check($sformatf("%s_missing%0d", tag, i), 32'd0, 32'd1);
            end
        end
        check({tag, "_nbeats"}, 32'(cap_td.size() - b), 32'(exp_td.size()));
        exp_td.delete();
        exp_sof.delete();
        exp_eof.delete();
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_flags", {26'h0, fifo_rd_en, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n, busy},
              32'b011110);
        check("rst_td", trn_td, 32'h0);
        check("rst_cnt", {16'h0, tlp_cnt}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycles(2);

        // MRd32, len 16, tag 5
        base = cap_td.size();
        push_cmd(mk_cmd(1'b0, 8'h05, 10'd16, 32'h0, 32'h0, 32'h1234_5678));
        wait_beats(base + 3, 40, "mrd32_wait");
        cycles(3);
        exp_beat(32'h0000_0010, 1'b0, 1'b1);
        exp_beat(32'h0A1B_05FF, 1'b1, 1'b1);
        exp_beat(32'h1234_5678, 1'b1, 1'b0);
        check_beats(base, "mrd32");
        check("mrd32_contig", 32'(cap_cyc[base+2] - cap_cyc[base]), 32'd2);
        check("mrd32_cnt", {16'h0, tlp_cnt}, 32'd1);
        check("mrd32_busy", {31'h0, busy}, 32'd0);
        check("mrd32_pops", 32'(rd_cnt), 32'd1);

        // MWr with addr_hi=1 (tag and len fields must be ignored)
        base = cap_td.size();
        push_cmd(mk_cmd(1'b1, 8'h77, 10'd5, 32'hDEAD_BEEF, 32'h0000_0001, 32'hABCD_0003));
`ifdef US_CMD_TLP_ADDR64_EN
        wait_beats(base + 5, 40, "mwr_wait");
        exp_beat(32'h6000_0001, 1'b0, 1'b1);
        exp_beat(32'h0A1B_000F, 1'b1, 1'b1);
        exp_beat(32'h0000_0001, 1'b1, 1'b1);
        exp_beat(32'hABCD_0000, 1'b1, 1'b1);
        exp_beat(32'hDEAD_BEEF, 1'b1, 1'b0);
`else
        wait_beats(base + 4, 40, "mwr_wait");
        exp_beat(32'h4000_0001, 1'b0, 1'b1);
        exp_beat(32'h0A1B_000F, 1'b1, 1'b1);
        exp_beat(32'hABCD_0000, 1'b1, 1'b1);
        exp_beat(32'hDEAD_BEEF, 1'b1, 1'b0);
`endif
        cycles(3);
        check_beats(base, "mwr");
        check("mwr_cnt", {16'h0, tlp_cnt}, 32'd2);

        // Backpressure on HDR1 for 5 cycles
        base = cap_td.size();
        rd0 = rd_cnt;
        push_cmd(mk_cmd(1'b0, 8'h3C, 10'd2, 32'h0, 32'h0, 32'h0000_1000));
        wait_beats(base + 1, 30, "bp_hdr0");
        trn_tdst_rdy_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold%0d", i), trn_td, 32'h0A1B_3CFF);
            @(posedge clk); #1;
        end
        trn_tdst_rdy_n = 1'b0;
        wait_beats(base + 3, 30, "bp_wait");
        cycles(3);
        exp_beat(32'h0000_0002, 1'b0, 1'b1);
        exp_beat(32'h0A1B_3CFF, 1'b1, 1'b1);
        exp_beat(32'h0000_1000, 1'b1, 1'b0);
        check_beats(base, "bp");
        check("bp_pops", 32'(rd_cnt - rd0), 32'd1);
        check("bp_cnt", {16'h0, tlp_cnt}, 32'd3);

        // Gating by bus-master enable and buffer availability
        base = cap_td.size();
        rd0 = rd_cnt;
        bme = 1'b0;
        push_cmd(mk_cmd(1'b0, 8'h01, 10'd1, 32'h0, 32'h0, 32'h0000_0100));
        push_cmd(mk_cmd(1'b0, 8'h02, 10'd2, 32'h0, 32'h0, 32'h0000_0200));
        push_cmd(mk_cmd(1'b0, 8'h03, 10'd3, 32'h0, 32'h0, 32'h0000_0300));
        cycles(10);
        check("gate_bme_pops", 32'(rd_cnt - rd0), 32'd0);
        check("gate_bme_busy", {31'h0, busy}, 32'd0);
        trn_tbuf_av = 6'd0;
        bme = 1'b1;
        cycles(10);
        check("gate_buf_pops", 32'(rd_cnt - rd0), 32'd0);
        trn_tbuf_av = 6'd4;
        wait_beats(base + 9, 100, "gate_wait");
        cycles(3);
        exp_beat(32'h0000_0001, 1'b0, 1'b1);
        exp_beat(32'h0A1B_010F, 1'b1, 1'b1);
        exp_beat(32'h0000_0100, 1'b1, 1'b0);
        exp_beat(32'h0000_0002, 1'b0, 1'b1);
        exp_beat(32'h0A1B_02FF, 1'b1, 1'b1);
        exp_beat(32'h0000_0200, 1'b1, 1'b0);
        exp_beat(32'h0000_0003, 1'b0, 1'b1);
        exp_beat(32'h0A1B_03FF, 1'b1, 1'b1);
        exp_beat(32'h0000_0300, 1'b1, 1'b0);
        check_beats(base, "gate");
        if (cap_cyc.size() >= base + 9) begin
            check("gate_gap1", 32'(cap_cyc[base+3] - cap_cyc[base+2]), 32'd4);
            check("gate_gap2", 32'(cap_cyc[base+6] - cap_cyc[base+5]), 32'd4);
        end else begin
            check("gate_gap_beats", 32'(cap_cyc.size()), 32'(base + 9));
        end
        check("gate_cnt", {16'h0, tlp_cnt}, 32'd6);
        check("gate_pops", 32'(rd_cnt - rd0), 32'd3);
        check("gate_empty", {31'h0, fifo_empty}, 32'd1);

        // Reset during HDR1, then a length-0 MRd goes out cleanly
        base = cap_td.size();
        rd0 = rd_cnt;
        push_cmd(mk_cmd(1'b0, 8'h11, 10'd4, 32'h0, 32'h0, 32'h0000_2000));
        push_cmd(mk_cmd(1'b0, 8'h22, 10'd0, 32'h0, 32'h0, 32'hFFFF_FFFF));
        wait_beats(base + 1, 30, "rst_hdr0");
        check("rst_pre_td", trn_td, 32'h0A1B_11FF);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_flags", {29'h0, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n}, 32'b111);
        check("rst_async_cnt", {16'h0, tlp_cnt}, 32'd0);
        cycles(2);
        base = cap_td.size();
        rst_n = 1'b1;
        wait_beats(base + 3, 40, "len0_wait");
        cycles(3);
        exp_beat(32'h0000_0000, 1'b0, 1'b1);
        exp_beat(32'h0A1B_22FF, 1'b1, 1'b1);
        exp_beat(32'hFFFF_FFFC, 1'b1, 1'b0);
        check_beats(base, "len0");
        check("len0_cnt", {16'h0, tlp_cnt}, 32'd1);
        check("len0_pops", 32'(rd_cnt - rd0), 32'd2);
        check("len0_empty", {31'h0, fifo_empty}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
